// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational 64-bit ALU; mul/div hold it MULDIV_LAT cycles.
// Define ALU_ARB_RR_EN for round-robin grants; default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_op,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [63:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_op,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [63:0] rsp1_result,
  output logic        rsp1_zero,
  input  logic        rsp1_ready,
  output logic [2:0]  alu_operation,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        gnt_q;
  logic [2:0]  op_q;
  logic [63:0] a_q, b_q;
  logic [3:0]  cnt_q;
  logic [63:0] res_q;
  logic        zero_q;

  logic        accept, sel;
  logic [2:0]  sel_op;
  logic [63:0] sel_a, sel_b;

`ifdef ALU_ARB_RR_EN
  logic prio_q;  // requester that wins the next tie

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio_q <= 1'b0;
    else if (accept) prio_q <= ~sel;
  end

  always_comb sel = (req0_valid && req1_valid) ? prio_q : !req0_valid;
`else
  always_comb sel = !req0_valid;
`endif

  // Ready is gated by reset so every output is low while reset is held.
  always_comb begin
    accept = reset_n && (state_q == IDLE) && (req0_valid || req1_valid);
    sel_op = sel ? req1_op : req0_op;
    sel_a  = sel ? req1_a  : req0_a;
    sel_b  = sel ? req1_b  : req0_b;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (gnt_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q <= sel;
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
        cnt_q <= (sel_op == OP_MUL || sel_op == OP_DIV) ? LAT_M1 : '0;
      end else if (state_q == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == EXEC && cnt_q == '0) begin
        // Divide by zero saturates regardless of what the ALU reports.
        if (op_q == OP_DIV && b_q == '0) begin
          res_q  <= '1;
          zero_q <= 1'b0;
        end else begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
        end
      end
    end
  end

  always_comb begin
    busy          = (state_q != IDLE);
    req0_ready    = accept && !sel;
    req1_ready    = accept && sel;
    alu_operation = (state_q == EXEC) ? op_q : '0;
    alu_a         = (state_q == EXEC) ? a_q  : '0;
    alu_b         = (state_q == EXEC) ? b_q  : '0;
    rsp0_valid    = (state_q == RESP) && !gnt_q;
    rsp1_valid    = (state_q == RESP) && gnt_q;
    rsp0_result   = rsp0_valid ? res_q : '0;
    rsp1_result   = rsp1_valid ? res_q : '0;
    rsp0_zero     = rsp0_valid && zero_q;
    rsp1_zero     = rsp1_valid && zero_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and random transactions checked against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0, rsp_ready = '0;
  logic [1:0]  req_ready, rsp_valid, rsp_zero;
  logic [2:0]  req_op [2];
  logic [63:0] req_a [2];
  logic [63:0] req_b [2];
  logic [63:0] rsp_result [2];
  logic [2:0]  alu_operation;
  logic [63:0] alu_a, alu_b, alu_result;
  logic        alu_zero, busy;
  int vectors = 0, miscompares = 0, cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Stand-in ALU; div by zero returns a marker the arbiter must override.
  function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return (b == 0) ? 64'h0BAD : a / b;
      3'b100:  return a * b;
      3'b101:  return a ^ b;
      3'b110:  return a - b;
      default: return {63'd0, a < b};
    endcase
  endfunction

  function automatic logic [63:0] exp_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    return (op == 3'b011 && b == 0) ? '1 : alu_fn(op, a, b);
  endfunction

  function automatic int exp_exec(input logic [2:0] op);
    return (op == 3'b100 || op == 3'b011) ? LAT : 1;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_operation, alu_a, alu_b);
    alu_zero   = (alu_result == 0);
  end

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_op(req_op[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req0_ready(req_ready[0]), .rsp0_valid(rsp_valid[0]), .rsp0_result(rsp_result[0]),
    .rsp0_zero(rsp_zero[0]), .rsp0_ready(rsp_ready[0]),
    .req1_valid(req_valid[1]), .req1_op(req_op[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req1_ready(req_ready[1]), .rsp1_valid(rsp_valid[1]), .rsp1_result(rsp_result[1]),
    .rsp1_zero(rsp_zero[1]), .rsp1_ready(rsp_ready[1]),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Drives one transaction; caller is at a falling edge. Returns observations only.
  task automatic issue(input int r, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold, input bit poke_other,
                       output int wait_cyc, output int lat, output int exec_ok, output int held,
                       output logic [63:0] res, output logic z, output bit anomaly);
    anomaly = 0; lat = -1; exec_ok = 0; held = 0; res = '0; z = 1'b0; wait_cyc = 0;
    req_valid[r] = 1'b1; req_op[r] = op; req_a[r] = a; req_b[r] = b; rsp_ready[r] = 1'b0;
    #1;
    while (!req_ready[r] && wait_cyc < 100) begin
      @(negedge clk); #1; wait_cyc++;
    end
    if (!req_ready[r]) begin
      req_valid[r] = 1'b0;
      return;
    end
    if (req_ready[1-r]) anomaly = 1;
    @(negedge clk);
    req_valid[r] = 1'b0;
    if (poke_other) req_valid[1-r] = 1'b1;
    #1;
    lat = 1;
    while (!rsp_valid[r] && lat < 100) begin
      if (busy && alu_operation == op && alu_a == a && alu_b == b) exec_ok++;
      if (req_ready != 2'b00 || rsp_valid != 2'b00 || !busy) anomaly = 1;
      @(negedge clk); #1; lat++;
    end
    res = rsp_result[r]; z = rsp_zero[r];
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid[r] && rsp_result[r] === res && rsp_zero[r] === z && busy &&
          !rsp_valid[1-r] && req_ready == 2'b00) held++;
      @(negedge clk); #1;
    end
    if (rsp_valid[1-r] || rsp_result[1-r] != 0) anomaly = 1;
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({busy, req_ready, rsp_valid, rsp_zero, alu_operation} !== '0 || alu_a !== '0 || alu_b !== '0 ||
        rsp_result[0] !== '0 || rsp_result[1] !== '0) begin
      miscompares++; $display("FAIL reset_outputs: busy=%0b ready=%b rsp_valid=%b op=%0d want all 0",
                              busy, req_ready, rsp_valid, alu_operation);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %0b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_add();
    int w, lat, ex, held; logic [63:0] res; logic z; bit an;
    issue(0, 3'b010, 64'd5, 64'd7, 0, 0, w, lat, ex, held, res, z, an);
    vectors++;
    if (res !== 64'd12 || z !== 1'b0) begin
      miscompares++; $display("FAIL add_result: got %0d/%0b want 12/0", res, z);
    end
    vectors++;
    if (lat !== 2 || ex !== 1 || w !== 0 || an) begin
      miscompares++; $display("FAIL add_timing: lat=%0d exec=%0d wait=%0d anomaly=%0b want 2/1/0/0", lat, ex, w, an);
    end
  endtask

  task automatic test_sub_stall();
    int w, lat, ex, held; logic [63:0] res; logic z; bit an;
    req_op[0] = 3'b010; req_a[0] = 64'd1; req_b[0] = 64'd2;
    issue(1, 3'b110, 64'd9, 64'd9, 5, 1, w, lat, ex, held, res, z, an);
    vectors++;
    if (res !== 64'd0 || z !== 1'b1) begin
      miscompares++; $display("FAIL sub_result: got %0d/%0b want 0/1", res, z);
    end
    vectors++;
    if (held !== 5 || an) begin
      miscompares++; $display("FAIL sub_stall_hold: held=%0d anomaly=%0b want 5/0", held, an);
    end
    issue(0, 3'b010, 64'd1, 64'd2, 0, 0, w, lat, ex, held, res, z, an);
    vectors++;
    if (w !== 0 || res !== 64'd3 || an) begin
      miscompares++; $display("FAIL stalled_req0: wait=%0d res=%0d anomaly=%0b want 0/3/0", w, res, an);
    end
  endtask

  task automatic test_mul();
    int w, lat, ex, held; logic [63:0] res; logic z; bit an;
    issue(0, 3'b100, 64'd6, 64'd7, 0, 0, w, lat, ex, held, res, z, an);
    vectors++;
    if (res !== 64'd42 || z !== 1'b0) begin
      miscompares++; $display("FAIL mul_result: got %0d/%0b want 42/0", res, z);
    end
    vectors++;
    if (lat !== LAT + 1 || ex !== LAT || an) begin
      miscompares++; $display("FAIL mul_timing: lat=%0d exec=%0d anomaly=%0b want %0d/%0d/0", lat, ex, an, LAT + 1, LAT);
    end
  endtask

  task automatic test_div0();
    int w, lat, ex, held; logic [63:0] res; logic z; bit an;
    issue(1, 3'b011, 64'd10, 64'd0, 1, 0, w, lat, ex, held, res, z, an);
    vectors++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || z !== 1'b0) begin
      miscompares++; $display("FAIL div0_result: got %0h/%0b want ffffffffffffffff/0", res, z);
    end
    vectors++;
    if (lat !== LAT + 1 || ex !== LAT || held !== 1 || an) begin
      miscompares++; $display("FAIL div0_timing: lat=%0d exec=%0d held=%0d want %0d/%0d/1", lat, ex, held, LAT + 1, LAT);
    end
  endtask

  task automatic test_random();
    int w, lat, ex, held, r, hold; logic [63:0] res, a, b, er; logic z; bit an; logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(1, 0));
      op = 3'($urandom_range(7, 0));
      a = ($urandom_range(3, 0) == 0) ? 64'($urandom_range(20, 0)) : {$urandom, $urandom};
      b = ($urandom_range(3, 0) == 0) ? 64'($urandom_range(3, 0)) : {$urandom, $urandom};
      hold = int'($urandom_range(3, 0));
      er = exp_result(op, a, b);
      issue(r, op, a, b, hold, 0, w, lat, ex, held, res, z, an);
      vectors++;
      if (res !== er || z !== (er == 0)) begin
        miscompares++; $display("FAIL rand_result[%0d]: req%0d op=%0d got %0h/%0b want %0h/%0b", n, r, op, res, z, er, er == 0);
      end
      vectors++;
      if (lat !== exp_exec(op) + 1 || ex !== exp_exec(op) || held !== hold || w !== 0 || an) begin
        miscompares++; $display("FAIL rand_timing[%0d]: op=%0d lat=%0d exec=%0d held=%0d an=%0b want %0d/%0d/%0d/0",
                                n, op, lat, ex, held, an, exp_exec(op) + 1, exp_exec(op), hold);
      end
    end
  endtask

  task automatic test_back_to_back();
    int order[$]; int done [2]; int exp_order [6]; int acc, last_acc, exp_r; bit pending;
    logic [63:0] exp_res;
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 1, 1, 1};
`endif
    do_reset();
    done = '{0, 0}; pending = 0; last_acc = -1; exp_r = 0; exp_res = '0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_op[i] = 3'b010; req_a[i] = {$urandom, $urandom}; req_b[i] = {$urandom, $urandom};
    end
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 200 && (order.size() < 6 || pending); c++) begin
      acc = req_ready[0] ? 0 : (req_ready[1] ? 1 : -1);
      if (pending && rsp_valid[exp_r]) begin
        vectors++;
        if (rsp_result[exp_r] !== exp_res) begin
          miscompares++; $display("FAIL b2b_result: req%0d got %0h want %0h", exp_r, rsp_result[exp_r], exp_res);
        end
        pending = 0;
      end
      if (acc >= 0) begin
        if (last_acc >= 0) begin
          vectors++;
          if (cycle - last_acc !== 3) begin
            miscompares++; $display("FAIL b2b_issue_period: got %0d want 3", cycle - last_acc);
          end
        end
        last_acc = cycle;
        order.push_back(acc);
        exp_r = acc; exp_res = req_a[acc] + req_b[acc]; pending = 1;
      end
      @(negedge clk);
      if (acc >= 0) begin
        done[acc]++;
        if (done[acc] == 3) req_valid[acc] = 1'b0;
        else begin
          req_a[acc] = {$urandom, $urandom}; req_b[acc] = {$urandom, $urandom};
        end
      end
      #1;
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    vectors++;
    if (order.size() !== 6 || pending) begin
      miscompares++; $display("FAIL b2b_grants: got %0d grants pending=%0b want 6/0", order.size(), pending);
    end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      vectors++;
      if (order[i] !== exp_order[i]) begin
        miscompares++; $display("FAIL b2b_order[%0d]: got req%0d want req%0d", i, order[i], exp_order[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    int w, lat, ex, held, seen, t; logic [63:0] res; logic z; bit an;
    req_valid[0] = 1'b1; req_op[0] = 3'b100; req_a[0] = 64'd6; req_b[0] = 64'd7;
    #1;
    t = 0;
    while (!req_ready[0] && t < 50) begin @(negedge clk); #1; t++; end
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b1 || alu_operation !== 3'b100) begin
      miscompares++; $display("FAIL rst_exec_pre: busy=%0b op=%0d want 1/4", busy, alu_operation);
    end
    reset_n = 1'b0; req_valid[1] = 1'b1; #1;
    vectors++;
    if ({busy, req_ready, rsp_valid, alu_operation} !== '0 || alu_a !== '0 || alu_b !== '0) begin
      miscompares++; $display("FAIL rst_exec_outputs: busy=%0b ready=%b op=%0d a=%0d want all 0",
                              busy, req_ready, alu_operation, alu_a);
    end
    @(negedge clk); req_valid[1] = 1'b0; reset_n = 1'b1;
    rsp_ready = 2'b11; seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (rsp_valid != 2'b00 || busy) seen++;
      @(negedge clk);
    end
    rsp_ready = 2'b00;
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL rst_exec_abandon: got %0d active cycles want 0", seen); end
    issue(1, 3'b010, 64'd100, 64'd23, 0, 0, w, lat, ex, held, res, z, an);
    vectors++;
    if (res !== 64'd123 || lat !== 2 || an) begin
      miscompares++; $display("FAIL rst_exec_next: res=%0d lat=%0d want 123/2", res, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin req_op[i] = '0; req_a[i] = '0; req_b[i] = '0; end
    test_reset();
    test_add();
    test_sub_stall();
    test_mul();
    test_div0();
    test_random();
    test_back_to_back();
    test_reset_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MULDIV_LAT, default 4: cycles the shared ALU is held for multiply (3'b100) or divide (3'b011); legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op / req0_a / req0_b  input  3/64/64  requester 0 ALU opcode and operands.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 rsp0_valid / rsp0_result / rsp0_zero  output  1/64/1  requester 0 response.
REQ-008 rsp0_ready  input  1  requester 0 consumes response.
REQ-009 req1_*, rsp1_*  same widths and meaning as REQ-004..REQ-008, for requester 1.
REQ-010 alu_operation / alu_a / alu_b  output  3/64/64  drive the shared ALU.
REQ-011 alu_result / alu_zero  input  64/1  combinational ALU outputs.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle only, latch op/a/b and grant id, go EXEC; otherwise stay IDLE.
REQ-015 reqN_ready SHALL be low outside IDLE and low for the non-granted requester.
REQ-016 EXEC: alu_operation/alu_a/alu_b SHALL equal latched values for every EXEC cycle and SHALL be 0 in IDLE and RESP.
REQ-017 EXEC length: MULDIV_LAT cycles for ops 3'b100 and 3'b011; 1 cycle for all other opcodes, including 3'b000, 3'b110 and 3'b111.
REQ-018 Last EXEC cycle: register alu_result and alu_zero into the response register, go RESP.
REQ-019 Divide with latched b == 0: response result SHALL be 64'hFFFF_FFFF_FFFF_FFFF and zero 0, regardless of ALU output; EXEC length unchanged.
REQ-020 RESP: rspN_valid high only for granted requester; rspN_result/rspN_zero stable until handshake.
REQ-021 RESP with rspN_ready high: response retired that cycle, go IDLE; new grant earliest next cycle.
REQ-022 RESP with rspN_ready low: hold indefinitely; no new acceptance.
REQ-023 Non-granted rsp*_valid SHALL be 0; rsp*_result/rsp*_zero SHALL be 0 when their rsp*_valid is low.
REQ-024 Requests SHALL NOT be dropped: a valid held high is eventually granted under either arbitration mode when the other requester idles.
REQ-025 Minimum issue-to-issue period: 3 cycles for 1-cycle ops, MULDIV_LAT+2 for mul/div.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, all outputs 0, latched operands 0, EXEC counter 0, arbitration pointer favouring requester 0.
REQ-027 Reset during EXEC or RESP SHALL abandon the operation; no response is ever issued for it.

Configuration
REQ-028 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not granted last; pointer updates only on acceptance.
REQ-029 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer register exists.

Verification
REQ-030 After reset, req0 add a=5 b=7 -> req0_ready 1 cycle, alu_operation=3'b010 1 cycle, rsp0_valid with result 12, zero 0.
REQ-031 req1 sub a=9 b=9, rsp1_ready held low 5 cycles -> rsp1_valid held 5+ cycles, result 0, zero 1, busy high throughout, req0 stalled.
REQ-032 req0 mul a=6 b=7, MULDIV_LAT=4 -> alu_operation=3'b100 exactly 4 cycles, rsp0 result 42, accept-to-rsp_valid 5 cycles.
REQ-033 req1 div a=10 b=0 -> rsp1 result 64'hFFFF_FFFF_FFFF_FFFF, zero 0.
REQ-034 Both valid continuously, three ops each: with ALU_ARB_RR_EN grants 0,1,0,1,0,1; without, all req0 ops before any req1.
REQ-035 reset_n low during EXEC of mul -> all outputs 0 same cycle, no rsp*_valid after release, next request serviced normally.
